// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC flit geometry, field offsets and field extraction helpers
package noc_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 2;
  localparam int FLIT_W = DATA_WIDTH + 2*ADDR_WIDTH;
  localparam int SRC_LSB = DATA_WIDTH + ADDR_WIDTH;
  localparam int DEST_LSB = DATA_WIDTH;
  typedef logic [FLIT_W-1:0] flit_t;
  function automatic logic [ADDR_WIDTH-1:0] flit_src(input flit_t f);
    return f[SRC_LSB +: ADDR_WIDTH];
  endfunction
  function automatic logic [ADDR_WIDTH-1:0] flit_dest(input flit_t f);
    return f[DEST_LSB +: ADDR_WIDTH];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] flit_payload(input flit_t f);
    return f[DATA_WIDTH-1:0];
  endfunction
  function automatic int rr_next(input int idx, input int n);
    return (idx == n-1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req/ptr in, one-hot grant + index + any out
module rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int IW = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [IW-1:0]     idx,
  output logic              any
);
  always_comb begin
    int best, d;
    best = NUM_IN;
    d = 0;
    idx = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      d = (j - int'(ptr) + NUM_IN) % NUM_IN;
      if (req[j] && d < best) begin
        best = d;
        idx = IW'(j);
      end
    end
  end
  assign any = |req;
  assign grant = any ? (NUM_IN'(1) << idx) : '0;
endmodule

// File: rtl/noc_port_arbiter.sv
// noc_port_arbiter: one-flit buffer per input, round-robin into a registered output stage
// ports: clk, rst (sync active-low), i_in_valid/i_in_data/o_in_ready per input,
//        o_valid/o_data/o_src_port/i_out_ready downstream, o_pkt_count delivered flits
module noc_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_IN = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_IN-1:0]                           i_in_valid,
  input  logic [NUM_IN*(DATA_WIDTH+2*ADDR_WIDTH)-1:0] i_in_data,
  output logic [NUM_IN-1:0]                           o_in_ready,
  output logic                                        o_valid,
  output logic [DATA_WIDTH+2*ADDR_WIDTH-1:0]          o_data,
  output logic [$clog2(NUM_IN)-1:0]                   o_src_port,
  input  logic                                        i_out_ready,
  output logic [15:0]                                 o_pkt_count
);
  import noc_pkg::*;
  localparam int FW = DATA_WIDTH + 2*ADDR_WIDTH;
  localparam int IW = $clog2(NUM_IN);
  logic [NUM_IN-1:0] buf_full, grant;
  logic [FW-1:0] buf_q [NUM_IN];
  logic [IW-1:0] rr_ptr, win;
  logic any, slot_free;
  rr_arbiter #(.NUM_IN(NUM_IN), .IW(IW)) u_arb (
    .req(buf_full), .ptr(rr_ptr), .grant(grant), .idx(win), .any(any)
  );
  assign o_in_ready = ~buf_full;
  assign slot_free = !o_valid || i_out_ready;
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_full <= '0;
      rr_ptr <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_src_port <= '0;
      o_pkt_count <= '0;
    end else begin
      // accept only into an empty buffer, grant only from a full one, so the two never collide
      for (int k = 0; k < NUM_IN; k++)
        if (i_in_valid[k] && !buf_full[k]) begin
          buf_full[k] <= 1'b1;
          buf_q[k] <= i_in_data[k*FW +: FW];
        end else if (slot_free && grant[k]) buf_full[k] <= 1'b0;
      if (slot_free) begin
        o_valid <= any;
        if (any) begin
          o_data <= buf_q[win];
          o_src_port <= win;
          rr_ptr <= IW'(rr_next(int'(win), NUM_IN));
        end
      end
      if (o_valid && i_out_ready) o_pkt_count <= o_pkt_count + 16'd1;
    end
  end
endmodule
